// File: rtl/pipe_hazard_ctrl.sv
// Interlock and forwarding controller for an in-order pipeline of parametrised depth.
// Tracks a shadow scoreboard of post-decode stages and drives enables, bubbles, flushes and forwarding selects.
module pipe_hazard_ctrl #(
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned BR_STAGE = 2,
    parameter int unsigned CNT_W    = 16,
    localparam int unsigned SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_wr,
    input  logic             id_rd_mem,
    input  logic             br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             back_en,
    output logic [SEL_W-1:0] fwd_sel_a,
    output logic [SEL_W-1:0] fwd_sel_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [DEPTH:1]   v_q, v_d, wr_q, wr_d, ld_q, ld_d;
    logic [4:0]       rd_q [1:DEPTH];
    logic [4:0]       rd_d [1:DEPTH];
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic             freeze, flush, load_use, shift;
    logic             ld_a, ld_b;
    logic [SEL_W-1:0] sel_a, sel_b;

    // Scan oldest to youngest so the youngest match wins.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        ld_a  = 1'b0;
        ld_b  = 1'b0;
        for (int unsigned k = DEPTH; k >= 1; k--) begin
            if (v_q[k] && wr_q[k] && rd_q[k] == id_rs1 && id_rs1 != 5'd0) begin
                sel_a = SEL_W'(k);
                ld_a  = ld_q[k] && (k <= LOAD_LAT);
            end
            if (v_q[k] && wr_q[k] && rd_q[k] == id_rs2 && id_rs2 != 5'd0) begin
                sel_b = SEL_W'(k);
                ld_b  = ld_q[k] && (k <= LOAD_LAT);
            end
        end
        if (!id_use_rs1) begin
            sel_a = '0;
            ld_a  = 1'b0;
        end
        if (!id_use_rs2) begin
            sel_b = '0;
            ld_b  = 1'b0;
        end
    end

    assign fwd_sel_a = sel_a;
    assign fwd_sel_b = sel_b;

    // Flush is masked during reset so a held br_taken cannot survive into reset.
    always_comb begin
        freeze   = mem_req & ~mem_ready;
        flush    = br_taken & ~freeze & ~rst;
        load_use = id_valid & (ld_a | ld_b) & ~freeze & ~flush;

        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        back_en      = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        shift        = 1'b1;

        if (freeze) begin
            if_id_en = 1'b0;
            id_ex_en = 1'b0;
            back_en  = 1'b0;
            shift    = 1'b0;
        end else if (flush) begin
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
        end else if (load_use) begin
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    // Wrong-path entries (older slots 1..BR_STAGE-1) land in slots 2..BR_STAGE after the shift.
    always_comb begin
        v_d  = v_q;
        wr_d = wr_q;
        ld_d = ld_q;
        rd_d = rd_q;
        if (shift) begin
            for (int unsigned k = DEPTH; k >= 2; k--) begin
                v_d[k]  = v_q[k-1];
                wr_d[k] = wr_q[k-1];
                ld_d[k] = ld_q[k-1];
                rd_d[k] = rd_q[k-1];
            end
            v_d[1]  = id_valid & ~flush & ~load_use;
            wr_d[1] = id_reg_wr;
            ld_d[1] = id_rd_mem;
            rd_d[1] = id_rd;
            if (flush) begin
                for (int unsigned k = 2; k <= DEPTH; k++) begin
                    if (k <= BR_STAGE) begin
                        v_d[k] = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((freeze || load_use) && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q         <= '0;
            wr_q        <= '0;
            ld_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                rd_q[k] <= '0;
            end
        end else begin
            v_q         <= v_d;
            wr_q        <= wr_d;
            ld_q        <= ld_d;
            rd_q        <= rd_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
